// File: rtl/aimc_mc_dist.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// aimc_mc_dist
// Multi-channel request distributor / ordered response merger placed between
// the interconnect and NUM_CH aimc_top instances.
//
// Requests: each user packet is steered to the channel named by the CH_W-bit
// field at ui_pkt[CH_SEL_LSB +: CH_W] and held in a one-entry per-channel
// output register until that channel takes it. Requests to a channel whose
// cal_done is low are held off.
//
// Responses: clean channel responses are parked in a per-channel buffer. An
// order FIFO records the channel of every accepted read, so responses reach
// the user strictly in read-accept order. Retry-flagged responses are dropped.
// Per-channel credits bound outstanding reads so no buffer can overflow.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cal_done        per-channel calibration complete (gates new requests)
//   ui_pkt*         user request packet / valid / read flag; ui_rdy accepts
//   ch_pkt*         per-channel request packet / valid, ch_rdy takes it
//   ch_rsp_*        per-channel response packet / valid pulse / retry flag
//   rsp_*           ordered response packet / valid / source channel, rsp_rdy
//   err_unexp       sticky per-channel flag: clean response nobody waited for
// ---------------------------------------------------------------------------
module aimc_mc_dist #(
  parameter int NUM_CH     = 4,
  parameter int PKT_W      = 256,
  parameter int CH_SEL_LSB = 0,
  parameter int MAX_OUTST  = 8,
  parameter int ORD_DEPTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           cal_done,
  input  logic [PKT_W-1:0]            ui_pkt,
  input  logic                        ui_pkt_valid,
  input  logic                        ui_pkt_rd,
  output logic                        ui_rdy,
  output logic [NUM_CH*PKT_W-1:0]     ch_pkt,
  output logic [NUM_CH-1:0]           ch_pkt_valid,
  input  logic [NUM_CH-1:0]           ch_rdy,
  input  logic [NUM_CH*PKT_W-1:0]     ch_rsp_pkt,
  input  logic [NUM_CH-1:0]           ch_rsp_valid,
  input  logic [NUM_CH-1:0]           ch_rsp_retry,
  output logic [PKT_W-1:0]            rsp_pkt,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_CH)-1:0]   rsp_ch,
  input  logic                        rsp_rdy,
  output logic [NUM_CH-1:0]           err_unexp
);

  localparam int CH_W = $clog2(NUM_CH);
  // Outstanding-read counter and response-buffer pointers share one width:
  // enough to hold the value MAX_OUTST itself (credit count and wrap bit).
  localparam int OW   = $clog2(MAX_OUTST) + 1;
  localparam int RA   = $clog2(MAX_OUTST);
  localparam int OA   = $clog2(ORD_DEPTH);
  localparam logic [OW-1:0] MAX_OUTST_V = OW'(MAX_OUTST);

  // -------------------------------------------------------------------------
  // Shared request / merge signals
  // -------------------------------------------------------------------------
  logic [CH_W-1:0]              w_sel;
  logic                         w_accept;
  logic                         w_rd_accept;
  logic                         w_deliver;
  logic [NUM_CH-1:0]            w_slot_free;
  logic [NUM_CH-1:0][OW-1:0]    w_outst;
  logic [NUM_CH-1:0]            w_rb_empty;
  logic [NUM_CH-1:0][PKT_W-1:0] w_rb_head;

  // Order FIFO: one channel index per accepted read.
  logic [CH_W-1:0]              r_ord_mem [ORD_DEPTH];
  logic [OA:0]                  r_ord_wr;
  logic [OA:0]                  r_ord_rd;
  logic                         w_ord_empty;
  logic                         w_ord_full;
  logic [CH_W-1:0]              w_head;

  assign w_sel = ui_pkt[CH_SEL_LSB +: CH_W];

  assign w_ord_empty = (r_ord_wr == r_ord_rd);
  assign w_ord_full  = (r_ord_wr[OA] != r_ord_rd[OA]) &&
                       (r_ord_wr[OA-1:0] == r_ord_rd[OA-1:0]);
  assign w_head      = r_ord_mem[r_ord_rd[OA-1:0]];

  // Ready looks only at registered state plus cal_done/ch_rdy of the target
  // channel. Credit and order-FIFO checks use this cycle's registered values,
  // so a delivery in the same cycle does not free a slot until the next one.
  assign ui_rdy = rst_n && cal_done[w_sel] && w_slot_free[w_sel] &&
                  (!ui_pkt_rd || ((w_outst[w_sel] < MAX_OUTST_V) && !w_ord_full));

  assign w_accept    = ui_pkt_valid && ui_rdy;
  assign w_rd_accept = w_accept && ui_pkt_rd;

  // Merge: the oldest read's channel must have data parked before anything
  // is presented; younger data on other channels waits behind it.
  assign rsp_valid = !w_ord_empty && !w_rb_empty[w_head];
  assign w_deliver = rsp_valid && rsp_rdy;
  assign rsp_pkt   = rsp_valid ? w_rb_head[w_head] : '0;
  assign rsp_ch    = rsp_valid ? w_head : '0;

  // -------------------------------------------------------------------------
  // Order FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      r_ord_wr <= '0;
      r_ord_rd <= '0;
    end else begin
      if (w_rd_accept) r_ord_wr <= r_ord_wr + 1'b1;
      if (w_deliver)   r_ord_rd <= r_ord_rd + 1'b1;
    end
  end

  // NOTE: storage arrays are left out of reset; an entry is only read after
  // it has been written, and the pointers (which are reset) decide validity.
  always_ff @(posedge clk) begin
    if (w_rd_accept) r_ord_mem[r_ord_wr[OA-1:0]] <= w_sel;
  end

  // -------------------------------------------------------------------------
  // Per-channel request slot, credit counter and response buffer
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             r_vld;
    logic [PKT_W-1:0] r_pkt;
    logic [OW-1:0]    r_outst;
    logic [OW-1:0]    r_rb_wr;
    logic [OW-1:0]    r_rb_rd;
    logic [PKT_W-1:0] r_rb_mem [MAX_OUTST];
    logic             r_err;

    logic             w_load;
    logic             w_inc;
    logic             w_dec;
    logic [OW-1:0]    w_rb_cnt;
    logic             w_clean;
    logic             w_waiting;
    logic             w_cap;
    logic             w_unexp;

    assign w_load    = w_accept && (w_sel == CH_W'(c));
    assign w_inc     = w_load && ui_pkt_rd;
    assign w_dec     = w_deliver && (w_head == CH_W'(c));

    assign w_rb_cnt  = r_rb_wr - r_rb_rd;
    assign w_clean   = ch_rsp_valid[c] && !ch_rsp_retry[c];
    // Reads still owed data = credits in use minus responses already parked.
    assign w_waiting = (r_outst > w_rb_cnt);
    assign w_cap     = w_clean && w_waiting;
    assign w_unexp   = w_clean && !w_waiting;

    // Slot can take a new packet when empty or being drained this cycle.
    assign w_slot_free[c]  = !r_vld || ch_rdy[c];
    assign w_outst[c]      = r_outst;
    assign w_rb_empty[c]   = (r_rb_wr == r_rb_rd);
    assign w_rb_head[c]    = r_rb_mem[r_rb_rd[RA-1:0]];

    assign ch_pkt_valid[c]           = r_vld;
    assign ch_pkt[c*PKT_W +: PKT_W]  = r_pkt;
    assign err_unexp[c]              = r_err;

    // Output register: loaded on accept, held stable until ch_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_pkt <= '0;
      end else if (w_load) begin
        r_vld <= 1'b1;
        r_pkt <= ui_pkt;
      end else if (r_vld && ch_rdy[c]) begin
        r_vld <= 1'b0;
      end
    end

    // Credits are returned only when the user takes the response, which
    // caps parked responses at MAX_OUTST.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_outst <= '0;
      end else if (w_inc && !w_dec) begin
        r_outst <= r_outst + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_outst <= r_outst - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rb_wr <= '0;
        r_rb_rd <= '0;
      end else begin
        if (w_cap) r_rb_wr <= r_rb_wr + 1'b1;
        if (w_dec) r_rb_rd <= r_rb_rd + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_cap) r_rb_mem[r_rb_wr[RA-1:0]] <= ch_rsp_pkt[c*PKT_W +: PKT_W];
    end

    // Sticky until reset: a clean response arrived with no read owed data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_err <= 1'b0;
      end else if (w_unexp) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aimc_mc_dist.sv
`timescale 1ns/1ps
// Self-checking bench for aimc_mc_dist (NUM_CH=4, PKT_W=256, MAX_OUTST=8,
// ORD_DEPTH=32). A transaction-level model (queues per channel plus a queue
// of read channels) predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_aimc_mc_dist;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    cal_done;
  logic [255:0]  ui_pkt;
  logic          ui_pkt_valid;
  logic          ui_pkt_rd;
  logic          ui_rdy;
  logic [1023:0] ch_pkt;
  logic [3:0]    ch_pkt_valid;
  logic [3:0]    ch_rdy;
  logic [1023:0] ch_rsp_pkt;
  logic [3:0]    ch_rsp_valid;
  logic [3:0]    ch_rsp_retry;
  logic [255:0]  rsp_pkt;
  logic          rsp_valid;
  logic [1:0]    rsp_ch;
  logic          rsp_rdy;
  logic [3:0]    err_unexp;

  int n_err = 0;
  int n_chk = 0;

  aimc_mc_dist #(
    .NUM_CH(4), .PKT_W(256), .CH_SEL_LSB(0), .MAX_OUTST(8), .ORD_DEPTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cal_done(cal_done),
    .ui_pkt(ui_pkt), .ui_pkt_valid(ui_pkt_valid), .ui_pkt_rd(ui_pkt_rd), .ui_rdy(ui_rdy),
    .ch_pkt(ch_pkt), .ch_pkt_valid(ch_pkt_valid), .ch_rdy(ch_rdy),
    .ch_rsp_pkt(ch_rsp_pkt), .ch_rsp_valid(ch_rsp_valid), .ch_rsp_retry(ch_rsp_retry),
    .rsp_pkt(rsp_pkt), .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_rdy(rsp_rdy),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  bit           m_vld   [4];
  logic [255:0] m_pkt   [4];
  int           m_outst [4];
  bit           m_err   [4];
  logic [255:0] m_rbuf  [4][$];
  int           m_ord   [$];

  function automatic bit exp_rdy();
    int s;
    s = int'(ui_pkt[1:0]);
    return rst_n && cal_done[s] && (!m_vld[s] || ch_rdy[s]) &&
           (!ui_pkt_rd || (m_outst[s] < 8 && m_ord.size() < 32));
  endfunction

  function automatic bit exp_rsp_valid();
    if (m_ord.size() == 0) return 1'b0;
    return m_rbuf[m_ord[0]].size() != 0;
  endfunction

  initial begin : model_proc
    bit acc, dlv, good;
    bit cap [4];
    int sel, head;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < 4; c++) begin
          m_vld[c] = 1'b0; m_outst[c] = 0; m_err[c] = 1'b0; m_rbuf[c].delete();
        end
        m_ord.delete();
      end else begin
        acc  = ui_pkt_valid && exp_rdy();
        dlv  = exp_rsp_valid() && rsp_rdy;
        sel  = int'(ui_pkt[1:0]);
        head = (m_ord.size() != 0) ? m_ord[0] : 0;
        for (int c = 0; c < 4; c++) begin
          good   = ch_rsp_valid[c] && !ch_rsp_retry[c];
          cap[c] = good && (m_outst[c] > m_rbuf[c].size());
          if (good && !cap[c]) m_err[c] = 1'b1;
          if (m_vld[c] && ch_rdy[c]) m_vld[c] = 1'b0;
        end
        if (dlv) begin
          void'(m_rbuf[head].pop_front());
          void'(m_ord.pop_front());
          m_outst[head]--;
        end
        for (int c = 0; c < 4; c++)
          if (cap[c]) m_rbuf[c].push_back(ch_rsp_pkt[c*256 +: 256]);
        if (acc) begin
          m_vld[sel] = 1'b1;
          m_pkt[sel] = ui_pkt;
          if (ui_pkt_rd) begin
            m_ord.push_back(sel);
            m_outst[sel]++;
          end
        end
      end
    end
  end

  task automatic cmp_outputs();
    logic [3:0] ev, ee;
    bit rv;
    for (int c = 0; c < 4; c++) begin
      ev[c] = m_vld[c];
      ee[c] = m_err[c];
    end
    rv = exp_rsp_valid();
    check("cyc_ui_rdy",       256'(ui_rdy),       256'(exp_rdy()));
    check("cyc_ch_pkt_valid", 256'(ch_pkt_valid), 256'(ev));
    check("cyc_rsp_valid",    256'(rsp_valid),    256'(rv));
    check("cyc_err_unexp",    256'(err_unexp),    256'(ee));
    if (rv) begin
      check("cyc_rsp_pkt", rsp_pkt, m_rbuf[m_ord[0]][0]);
      check("cyc_rsp_ch",  256'(rsp_ch), 256'(m_ord[0]));
    end
    for (int c = 0; c < 4; c++)
      if (m_vld[c]) check("cyc_ch_pkt", ch_pkt[c*256 +: 256], m_pkt[c]);
  endtask

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      cmp_outputs();
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (all start and end at posedge+1)
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int ch, input bit rd, input logic [253:0] data,
                      input int max_cyc, output bit ok);
    ui_pkt       = {data, 2'(ch)};
    ui_pkt_rd    = rd;
    ui_pkt_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = ui_rdy;
      step();
    end
    ui_pkt_valid = 1'b0;
  endtask

  task automatic respond(input int ch, input bit retry, input logic [255:0] data);
    ch_rsp_pkt[ch*256 +: 256] = data;
    ch_rsp_valid[ch] = 1'b1;
    ch_rsp_retry[ch] = retry;
    step();
    ch_rsp_valid[ch] = 1'b0;
    ch_rsp_retry[ch] = 1'b0;
  endtask

  task automatic deliver_one(input int ch, input logic [255:0] data, input int max_cyc);
    bit got;
    got = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        check("dlv_ch",  256'(rsp_ch), 256'(ch));
        check("dlv_pkt", rsp_pkt, data);
      end
      step();
    end
    rsp_rdy = 1'b0;
    check("dlv_seen", 256'(got), 256'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------
  initial begin : stim
    bit ok;
    int n_acc;
    rst_n = 1'b0; cal_done = 4'hF; ui_pkt = '0; ui_pkt_valid = 1'b0; ui_pkt_rd = 1'b0;
    ch_rdy = 4'hF; ch_rsp_pkt = '0; ch_rsp_valid = '0; ch_rsp_retry = '0; rsp_rdy = 1'b0;
    repeat (2) step();
    check("rst_ui_rdy",       256'(ui_rdy),       256'(0));
    check("rst_ch_pkt_valid", 256'(ch_pkt_valid), 256'(0));
    check("rst_rsp_valid",    256'(rsp_valid),    256'(0));
    check("rst_err_unexp",    256'(err_unexp),    256'(0));
    check("rst_ch_pkt",       256'(ch_pkt[255:0] | ch_pkt[1023:768]), 256'(0));
    rst_n = 1'b1;
    step();

    // Order: reads to 2, 0, 1; responses come back 1, 0, 2.
    send(2, 1'b1, 254'h2A, 4, ok); check("ord_acc2", 256'(ok), 256'(1));
    send(0, 1'b1, 254'h0A, 4, ok); check("ord_acc0", 256'(ok), 256'(1));
    send(1, 1'b1, 254'h1A, 4, ok); check("ord_acc1", 256'(ok), 256'(1));
    respond(1, 1'b0, 256'hC1);
    @(negedge clk); check("ord_wait_after_ch1", 256'(rsp_valid), 256'(0));
    step();
    respond(0, 1'b0, 256'hB0);
    @(negedge clk); check("ord_wait_after_ch0", 256'(rsp_valid), 256'(0));
    step();
    respond(2, 1'b0, 256'hA2);
    @(negedge clk);
    check("ord_lat1_valid", 256'(rsp_valid), 256'(1));
    check("ord_lat1_ch",    256'(rsp_ch),    256'(2));
    step();
    deliver_one(2, 256'hA2, 4);
    deliver_one(0, 256'hB0, 4);
    deliver_one(1, 256'hC1, 4);

    // Retry: dropped response, then a clean one delivered exactly once.
    send(0, 1'b1, 254'h55, 4, ok); check("rty_acc", 256'(ok), 256'(1));
    respond(0, 1'b1, 256'hBAD);
    @(negedge clk);
    check("rty_no_valid", 256'(rsp_valid), 256'(0));
    check("rty_no_err",   256'(err_unexp), 256'(0));
    step();
    respond(0, 1'b0, 256'hD0);
    deliver_one(0, 256'hD0, 4);
    @(negedge clk);
    check("rty_only_one", 256'(rsp_valid), 256'(0));
    check("rty_err0",     256'(err_unexp[0]), 256'(0));
    step();

    // Gating: ch1 not calibrated, then raised; packet held until ch_rdy[1].
    cal_done = 4'b1101; ch_rdy[1] = 1'b0;
    ui_pkt = {254'h77, 2'd1}; ui_pkt_rd = 1'b0; ui_pkt_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); check("gate_blocked", 256'(ui_rdy), 256'(0));
      step();
    end
    cal_done = 4'hF;
    @(negedge clk); check("gate_open", 256'(ui_rdy), 256'(1));
    step();
    ui_pkt_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("gate_held_valid", 256'(ch_pkt_valid[1]), 256'(1));
      check("gate_held_pkt",   ch_pkt[256 +: 256],    {254'h77, 2'd1});
      step();
    end
    ch_rdy[1] = 1'b1;
    step();
    @(negedge clk); check("gate_drained", 256'(ch_pkt_valid[1]), 256'(0));
    step();

    // Credits: 8 reads to ch3 accepted, 9th waits for one delivery.
    ui_pkt = {254'h33, 2'd3}; ui_pkt_rd = 1'b1; ui_pkt_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ui_rdy) n_acc++;
      step();
    end
    check("cred_accepted", 256'(n_acc), 256'(8));
    @(negedge clk); check("cred_blocked", 256'(ui_rdy), 256'(0));
    step();
    respond(3, 1'b0, 256'h3F0);
    deliver_one(3, 256'h3F0, 4);
    @(negedge clk); check("cred_returned", 256'(ui_rdy), 256'(1));
    step();
    ui_pkt_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      respond(3, 1'b0, 256'h300 + 256'(k));
      deliver_one(3, 256'h300 + 256'(k), 4);
    end
    @(negedge clk); check("cred_drained", 256'(rsp_valid), 256'(0));
    step();

    // Unexpected: clean response on ch2 with nothing outstanding.
    respond(2, 1'b0, 256'hEE);
    @(negedge clk);
    check("unexp_flag",     256'(err_unexp), 256'(4'b0100));
    check("unexp_no_valid", 256'(rsp_valid), 256'(0));
    step();

    // Reset mid-traffic: pending response, held packet, sticky error.
    send(0, 1'b1, 254'h60, 4, ok); check("mid_acc0", 256'(ok), 256'(1));
    send(1, 1'b1, 254'h61, 4, ok); check("mid_acc1", 256'(ok), 256'(1));
    respond(0, 1'b0, 256'h5A);
    ch_rdy[1] = 1'b0;
    send(1, 1'b0, 254'h62, 4, ok); check("mid_acc_wr", 256'(ok), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ui_rdy",       256'(ui_rdy),       256'(0));
    check("mid_rst_ch_pkt_valid", 256'(ch_pkt_valid), 256'(0));
    check("mid_rst_rsp_valid",    256'(rsp_valid),    256'(0));
    check("mid_rst_err_unexp",    256'(err_unexp),    256'(0));
    step();
    rst_n = 1'b1; ch_rdy = 4'hF;
    repeat (3) begin
      @(negedge clk); check("mid_no_stale", 256'(rsp_valid), 256'(0));
      step();
    end
    send(0, 1'b1, 254'h70, 4, ok); check("post_acc", 256'(ok), 256'(1));
    respond(0, 1'b0, 256'h77);
    deliver_one(0, 256'h77, 4);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
